// File: rtl/ghr_checkpoint_mgr_pkg.sv
// Shared types and helpers for the gshare global-history checkpoint manager.
package ghr_checkpoint_mgr_pkg;

    localparam int GHR_WIDTH_DEF = 8;
    localparam int DEPTH_DEF     = 8;
    localparam int GHR_MAX       = 32;

    typedef struct packed {
        logic [GHR_WIDTH_DEF-1:0] snapshot;
        logic                     pred_taken;
    } ckpt_entry_t;

    // Callers zero-extend into GHR_MAX bits and truncate the result back to their width.
    function automatic logic [GHR_MAX-1:0] ghr_shift(input logic [GHR_MAX-1:0] hist,
                                                     input logic bit_in);
        return (hist << 1) | GHR_MAX'(bit_in);
    endfunction

endpackage

// File: rtl/ghr_ckpt_fifo.sv
// Synchronous checkpoint FIFO with clear; clear wins over push and pop.
module ghr_ckpt_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ghr_checkpoint_mgr.sv
// Speculative/committed global history owner with per-branch GHR checkpoints and PHT update strobe.
module ghr_checkpoint_mgr
    import ghr_checkpoint_mgr_pkg::*;
#(
    parameter int GHR_WIDTH = GHR_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 if1_pred_valid,
    input  logic                 if1_pred_taken,
    output logic [GHR_WIDTH-1:0] ghr_spec,
    output logic                 ckpt_full,
    input  logic                 ex_resolve_valid,
    input  logic                 ex_taken,
    input  logic                 ex_mispredict,
    input  logic                 flush,
    output logic                 pht_we,
    output logic                 pht_branched,
    output logic [GHR_WIDTH-1:0] pht_ghr,
    output logic [GHR_WIDTH-1:0] ghr_arch,
    output logic                 err_underflow
);

    logic [GHR_WIDTH:0]   head;
    logic [GHR_WIDTH-1:0] head_snap;
    logic                 head_pred_unused;
    logic                 fifo_empty;
    logic                 resolve_ok;
    logic                 mispred;
    logic                 push_ok;
    logic [GHR_WIDTH-1:0] ghr_arch_nxt;

    assign head_snap        = head[GHR_WIDTH:1];
    assign head_pred_unused = head[0];

    assign resolve_ok = ex_resolve_valid && !fifo_empty;
    assign mispred    = resolve_ok && ex_mispredict;
    // Fullness is the start-of-cycle value, so a same-cycle pop never admits the push.
    assign push_ok    = if1_pred_valid && !ckpt_full && !flush && !(ex_resolve_valid && ex_mispredict);

    always_comb begin
        ghr_arch_nxt = ghr_arch;
        if (resolve_ok) begin
            ghr_arch_nxt = GHR_WIDTH'(ghr_shift(GHR_MAX'(ghr_arch), ex_taken));
        end
    end

    ghr_ckpt_fifo #(
        .WIDTH (GHR_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .pop   (resolve_ok),
        .clear (flush || mispred),
        .data  ({ghr_spec, if1_pred_taken}),
        .head  (head),
        .full  (ckpt_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_spec      <= '0;
            ghr_arch      <= '0;
            pht_we        <= 1'b0;
            pht_branched  <= 1'b0;
            pht_ghr       <= '0;
            err_underflow <= 1'b0;
        end else begin
            pht_we   <= resolve_ok;
            ghr_arch <= ghr_arch_nxt;
            if (resolve_ok) begin
                pht_branched <= ex_taken;
                pht_ghr      <= head_snap;
            end
            if (ex_resolve_valid && fifo_empty) begin
                err_underflow <= 1'b1;
            end
            // Flush restores from committed history including this cycle's resolve.
            if (flush) begin
                ghr_spec <= ghr_arch_nxt;
            end else if (mispred) begin
                ghr_spec <= GHR_WIDTH'(ghr_shift(GHR_MAX'(head_snap), ex_taken));
            end else if (push_ok) begin
                ghr_spec <= GHR_WIDTH'(ghr_shift(GHR_MAX'(ghr_spec), if1_pred_taken));
            end
        end
    end

    a_head_matches_arch: assert property (@(posedge clk) disable iff (!rst_n)
        !fifo_empty |-> (head_snap == ghr_arch));

endmodule
